// File: rtl/solver_pkg.sv
// Shared encodings for the expression-solver datapath and its control block.
package solver_pkg;

  localparam int DATA_W_DEF = 8;

  typedef logic [1:0] sel_t;

  // ALU operation select
  localparam logic OP_ADD = 1'b0;
  localparam logic OP_MUL = 1'b1;

  // Operand A select
  localparam sel_t M0_RX   = 2'b00;
  localparam sel_t M0_RS   = 2'b01;
  localparam sel_t M0_RH   = 2'b10;
  localparam sel_t M0_CAPC = 2'b11;

  // Operand B select
  localparam sel_t M1_RX   = 2'b00;
  localparam sel_t M1_CAPA = 2'b01;
  localparam sel_t M1_CAPB = 2'b10;
  localparam sel_t M1_RH   = 2'b11;

  // Write-back source select (two codes alias the ALU result)
  localparam sel_t M2_ALU  = 2'b00;
  localparam sel_t M2_OPA  = 2'b01;
  localparam sel_t M2_ALU2 = 2'b10;
  localparam sel_t M2_ZERO = 2'b11;

  // True when the write-back source is the ALU result
  function automatic logic wb_uses_alu(input sel_t m2);
    return (m2 == M2_ALU) || (m2 == M2_ALU2);
  endfunction

endpackage

// File: rtl/solver_datapath_if.sv
// Host/control bus of the solver datapath: operand capture, control word,
// and the valid/ready result handshake with its sticky status flags.
interface solver_datapath_if #(
  parameter int DATA_W = solver_pkg::DATA_W_DEF
);
  logic              start;
  logic [DATA_W-1:0] x_in;
  logic [DATA_W-1:0] a_in;
  logic [DATA_W-1:0] b_in;
  logic [DATA_W-1:0] c_in;
  logic              LX;
  logic              LS;
  logic              LH;
  logic              OP;
  logic [1:0]        M0;
  logic [1:0]        M1;
  logic [1:0]        M2;
  logic              completed;
  logic [DATA_W-1:0] res_o;
  logic              res_valid;
  logic              res_ready;
  logic              ovf;
  logic              dropped;

  // Host + control block side
  modport master (
    output start, x_in, a_in, b_in, c_in,
    output LX, LS, LH, OP, M0, M1, M2, completed,
    output res_ready,
    input  res_o, res_valid, ovf, dropped
  );

  // Datapath side
  modport slave (
    input  start, x_in, a_in, b_in, c_in,
    input  LX, LS, LH, OP, M0, M1, M2, completed,
    input  res_ready,
    output res_o, res_valid, ovf, dropped
  );
endinterface

// File: rtl/solver_alu.sv
// Combinational unsigned add/multiply with a double-width internal result.
// Reports whether the upper half is nonzero and produces the write-back
// word: truncated, or all ones on overflow when SAT is set.
module solver_alu
  import solver_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter bit SAT    = 1'b0
) (
  input  logic              op,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic              hi_nz,
  output logic [DATA_W-1:0] wb
);

  localparam int W2 = 2 * DATA_W;

  logic [W2-1:0] full;

  // Full-width result, overflow detect and write-back word
  always_comb begin
    full = '0;
    if (op == OP_MUL) begin
      full = W2'(a) * W2'(b);
    end else begin
      full = W2'(a) + W2'(b);
    end
    hi_nz = |full[W2-1:DATA_W];
    wb    = full[DATA_W-1:0];
    if (SAT && hi_nz) begin
      wb = '1;
    end
  end

endmodule

// File: rtl/solver_datapath.sv
// Datapath responder for the expression-solver control FSM.
// Captures operands on start, executes the per-cycle control word
// (loads, operand muxing, ALU) and offers the final rS on a valid/ready
// output when completed arrives.
// Optional macro SOLVER_SAT_EN: ALU write-backs that overflow store all
// ones instead of the wrapped low bits.
module solver_datapath
  import solver_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
) (
  input logic               clk,
  input logic               rst,
  solver_datapath_if.slave  bus
);

`ifdef SOLVER_SAT_EN
  localparam bit SAT_EN = 1'b1;
`else
  localparam bit SAT_EN = 1'b0;
`endif

  logic [DATA_W-1:0] cap_x, cap_a, cap_b, cap_c;
  logic [DATA_W-1:0] rx, rs, rh;
  logic [DATA_W-1:0] res;
  logic              res_valid;
  logic              ovf;
  logic              dropped;

  logic [DATA_W-1:0] opa, opb;
  logic [DATA_W-1:0] alu_wb;
  logic              alu_hi_nz;
  logic [DATA_W-1:0] wb_val;
  logic              ovf_set;
  logic              accept;

  solver_alu #(
    .DATA_W (DATA_W),
    .SAT    (SAT_EN)
  ) u_alu (
    .op    (bus.OP),
    .a     (opa),
    .b     (opb),
    .hi_nz (alu_hi_nz),
    .wb    (alu_wb)
  );

  // Operand muxes, write-back source and overflow qualification
  always_comb begin
    opa = rx;
    case (bus.M0)
      M0_RX:   opa = rx;
      M0_RS:   opa = rs;
      M0_RH:   opa = rh;
      default: opa = cap_c;
    endcase

    opb = rx;
    case (bus.M1)
      M1_RX:   opb = rx;
      M1_CAPA: opb = cap_a;
      M1_CAPB: opb = cap_b;
      default: opb = rh;
    endcase

    wb_val = alu_wb;
    case (bus.M2)
      M2_OPA:  wb_val = opa;
      M2_ZERO: wb_val = '0;
      default: wb_val = alu_wb;
    endcase

    // Overflow only counts when an ALU result is actually written back
    ovf_set = wb_uses_alu(bus.M2) && (bus.LS || bus.LH) && alu_hi_nz;

    // A new result is taken if the slot is empty or being drained this cycle
    accept = !res_valid || bus.res_ready;
  end

  // Operand capture on start
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cap_x <= '0;
      cap_a <= '0;
      cap_b <= '0;
      cap_c <= '0;
    end else if (bus.start) begin
      cap_x <= bus.x_in;
      cap_a <= bus.a_in;
      cap_b <= bus.b_in;
      cap_c <= bus.c_in;
    end
  end

  // Working registers; every load sees pre-edge values
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx <= '0;
      rs <= '0;
      rh <= '0;
    end else begin
      if (bus.LX) rx <= cap_x;
      if (bus.LS) rs <= wb_val;
      if (bus.LH) rh <= wb_val;
    end
  end

  // Sticky overflow, cleared by a new start; a same-cycle overflow wins
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ovf <= 1'b0;
    end else if (ovf_set) begin
      ovf <= 1'b1;
    end else if (bus.start) begin
      ovf <= 1'b0;
    end
  end

  // Result handshake: load on completed when the slot can take it, else drop
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      res       <= '0;
      res_valid <= 1'b0;
      dropped   <= 1'b0;
    end else begin
      if (res_valid && bus.res_ready) begin
        res_valid <= 1'b0;
      end
      if (bus.completed) begin
        if (accept) begin
          res       <= rs;
          res_valid <= 1'b1;
        end else begin
          dropped <= 1'b1;
        end
      end
    end
  end

  assign bus.res_o     = res;
  assign bus.res_valid = res_valid;
  assign bus.ovf       = ovf;
  assign bus.dropped   = dropped;

endmodule

// File: tb/tb_solver_datapath.sv
// Self-checking bench for solver_datapath: scoreboard of expected results
// pushed when completed is driven, popped when a transfer is observed.
module tb_solver_datapath;
  import solver_pkg::*;

  localparam int W = 8;

`ifdef SOLVER_SAT_EN
  localparam logic [W-1:0] EXP_OVF_RES = 8'd255;
`else
  localparam logic [W-1:0] EXP_OVF_RES = 8'd144;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;

  int total = 0;
  int bad   = 0;

  logic [W-1:0] exp_q[$];
  logic [W-1:0] sb_exp;

  solver_datapath_if #(.DATA_W(W)) bus();

  solver_datapath #(.DATA_W(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s got=%0d want=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ctl(input logic lx, input logic ls, input logic lh, input logic op,
                     input logic [1:0] m0, input logic [1:0] m1, input logic [1:0] m2);
    bus.LX = lx; bus.LS = ls; bus.LH = lh; bus.OP = op;
    bus.M0 = m0; bus.M1 = m1; bus.M2 = m2;
    tick();
    bus.LX = 1'b0; bus.LS = 1'b0; bus.LH = 1'b0; bus.OP = 1'b0;
    bus.M0 = 2'b00; bus.M1 = 2'b00; bus.M2 = 2'b00;
  endtask

  task automatic do_start(input logic [W-1:0] x, input logic [W-1:0] a,
                          input logic [W-1:0] b, input logic [W-1:0] c);
    bus.start = 1'b1;
    bus.x_in = x; bus.a_in = a; bus.b_in = b; bus.c_in = c;
    tick();
    bus.start = 1'b0;
  endtask

  task automatic complete(input logic [W-1:0] exp_v, input bit accept);
    bus.completed = 1'b1;
    if (accept) exp_q.push_back(exp_v);
    tick();
    bus.completed = 1'b0;
  endtask

  // Scoreboard: a transfer happens at the next edge when valid and ready
  always @(negedge clk) begin
    if (!rst && bus.res_valid && bus.res_ready) begin
      if (exp_q.size() == 0) begin
        chk("sb_empty", exp_q.size(), 1);
      end else begin
        sb_exp = exp_q.pop_front();
        chk("sb_res", bus.res_o, sb_exp);
        $display("xfer res=%0d exp=%0d", bus.res_o, sb_exp);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    bus.start = 1'b0;
    bus.x_in = '0; bus.a_in = '0; bus.b_in = '0; bus.c_in = '0;
    bus.LX = 1'b0; bus.LS = 1'b0; bus.LH = 1'b0; bus.OP = 1'b0;
    bus.M0 = 2'b00; bus.M1 = 2'b00; bus.M2 = 2'b00;
    bus.completed = 1'b0;
    bus.res_ready = 1'b0;

    // Reset state
    #3;
    chk("rst_res",     bus.res_o,     0);
    chk("rst_valid",   bus.res_valid, 0);
    chk("rst_ovf",     bus.ovf,       0);
    chk("rst_dropped", bus.dropped,   0);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // T1: load rX, then rS = rX * a = 15
    do_start(8'd3, 8'd5, 8'd2, 8'd7);
    ctl(1'b1, 1'b0, 1'b0, OP_ADD, M0_RX, M1_RX, M2_ALU);
    ctl(1'b0, 1'b1, 1'b0, OP_MUL, M0_RX, M1_CAPA, M2_ALU);
    chk("t1_ovf", bus.ovf, 0);
    bus.res_ready = 1'b1;
    complete(8'd15, 1'b1);
    chk("t1_valid", bus.res_valid, 1);
    chk("t1_res",   bus.res_o,     15);
    tick();
    chk("t1_valid_clr", bus.res_valid, 0);

    // T2: Horner continuation 15+b=17, *x=51, rH=51, c+rH=58
    ctl(1'b0, 1'b1, 1'b0, OP_ADD, M0_RS, M1_CAPB, M2_ALU);
    ctl(1'b0, 1'b1, 1'b0, OP_MUL, M0_RS, M1_RX, M2_ALU2);
    ctl(1'b0, 1'b0, 1'b1, OP_ADD, M0_RS, M1_RX, M2_OPA);
    ctl(1'b0, 1'b1, 1'b0, OP_ADD, M0_CAPC, M1_RH, M2_ALU);
    bus.res_ready = 1'b0;
    complete(8'd58, 1'b1);
    chk("t2_valid", bus.res_valid, 1);
    chk("t2_res",   bus.res_o,     58);
    chk("t2_ovf",   bus.ovf,       0);

    // T4: backpressure hold, then a dropped second result
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("t4_hold",  bus.res_o,     58);
      chk("t4_valid", bus.res_valid, 1);
    end
    do_start(8'd9, 8'd5, 8'd2, 8'd7);
    ctl(1'b1, 1'b0, 1'b0, OP_ADD, M0_RX, M1_RX, M2_ALU);
    ctl(1'b0, 1'b1, 1'b0, OP_ADD, M0_RX, M1_RX, M2_OPA);
    complete(8'd0, 1'b0);
    chk("t4_res_kept", bus.res_o,     58);
    chk("t4_dropped",  bus.dropped,   1);
    chk("t4_valid2",   bus.res_valid, 1);
    bus.res_ready = 1'b1;
    tick();
    chk("t4_valid_clr",   bus.res_valid, 0);
    chk("t4_dropped_stk", bus.dropped,   1);
    complete(8'd9, 1'b1);
    chk("t4_res9", bus.res_o, 9);
    tick();

    // T6: asynchronous reset mid-sequence, result pending
    do_start(8'd3, 8'd5, 8'd2, 8'd7);
    ctl(1'b1, 1'b0, 1'b0, OP_ADD, M0_RX, M1_RX, M2_ALU);
    ctl(1'b0, 1'b1, 1'b0, OP_MUL, M0_RX, M1_CAPA, M2_ALU);
    bus.res_ready = 1'b0;
    complete(8'd15, 1'b1);
    chk("t6_pre_res", bus.res_o, 15);
    #2;
    rst = 1'b1;
    #1;
    chk("t6_res",     bus.res_o,     0);
    chk("t6_valid",   bus.res_valid, 0);
    chk("t6_ovf",     bus.ovf,       0);
    chk("t6_dropped", bus.dropped,   0);
    exp_q.delete();
    #2;
    rst = 1'b0;
    tick();
    bus.res_ready = 1'b1;
    complete(8'd0, 1'b1);
    chk("t6_rs_zero", bus.res_o, 0);
    tick();

    // T5: back-to-back completed while valid and ready
    do_start(8'd3, 8'd5, 8'd2, 8'd7);
    ctl(1'b1, 1'b0, 1'b0, OP_ADD, M0_RX, M1_RX, M2_ALU);
    ctl(1'b0, 1'b1, 1'b0, OP_MUL, M0_RX, M1_CAPA, M2_ALU);
    bus.res_ready = 1'b0;
    complete(8'd15, 1'b1);
    chk("t5_valid1", bus.res_valid, 1);
    ctl(1'b0, 1'b1, 1'b0, OP_ADD, M0_RS, M1_CAPB, M2_ALU);
    bus.res_ready = 1'b1;
    complete(8'd17, 1'b1);
    chk("t5_valid2",  bus.res_valid, 1);
    chk("t5_res",     bus.res_o,     17);
    chk("t5_dropped", bus.dropped,   0);
    tick();
    chk("t5_valid_clr", bus.res_valid, 0);

    // T3: overflow, zero write-back does not flag it, next start clears it
    do_start(8'd20, 8'd20, 8'd0, 8'd0);
    chk("t3_ovf_start", bus.ovf, 0);
    ctl(1'b1, 1'b0, 1'b0, OP_ADD, M0_RX, M1_RX, M2_ALU);
    ctl(1'b0, 1'b1, 1'b0, OP_MUL, M0_RX, M1_CAPA, M2_ZERO);
    chk("t3_ovf_zero_wb", bus.ovf, 0);
    ctl(1'b0, 1'b1, 1'b0, OP_MUL, M0_RX, M1_CAPA, M2_ALU);
    chk("t3_ovf_set", bus.ovf, 1);
    complete(EXP_OVF_RES, 1'b1);
    chk("t3_res", bus.res_o, 32'(EXP_OVF_RES));
    tick();
    do_start(8'd1, 8'd2, 8'd3, 8'd4);
    chk("t3_ovf_clr", bus.ovf, 0);

    // LS and LH together load the same value: rS=rH=c+a=6, then rS=rH+rH=12
    ctl(1'b0, 1'b1, 1'b1, OP_ADD, M0_CAPC, M1_CAPA, M2_ALU);
    ctl(1'b0, 1'b1, 1'b0, OP_ADD, M0_RH, M1_RH, M2_ALU);
    complete(8'd12, 1'b1);
    chk("dual_res", bus.res_o, 12);
    tick();
    tick();

    chk("sb_left", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/solver_datapath.md
Name: solver_datapath

Overview:
Datapath responder for the expression-solver control FSM. It consumes the per-cycle control word (LX, LS, LH, OP, M0, M1, M2, completed) and executes register loads, operand muxing and ALU operations on captured operands. When completed arrives, it latches the final result and offers it to the host on a valid/ready output handshake. It sits between the host operand bus and the control block.

Parameters:
DATA_W, 8, width of operands, registers, ALU result and output.

Ports:
clk  in  1  system clock, all state on rising edge
rst  in  1  asynchronous, active-high reset
start  in  1  capture pulse for x_in/a_in/b_in/c_in; same pulse the control block samples
x_in  in  DATA_W  variable x
a_in  in  DATA_W  coefficient a
b_in  in  DATA_W  coefficient b
c_in  in  DATA_W  coefficient c
LX  in  1  load rX from captured x
LS  in  1  load rS from write-back value
LH  in  1  load rH from write-back value
OP  in  1  ALU op: 0 = add, 1 = multiply
M0  in  2  ALU operand A: 00 rX, 01 rS, 10 rH, 11 cap_c
M1  in  2  ALU operand B: 00 rX, 01 cap_a, 10 cap_b, 11 rH
M2  in  2  write-back source: 00 ALU, 01 operand A, 10 ALU, 11 zero
completed  in  1  end of sequence; latch result
res_o  out  DATA_W  result (rS at completed)
res_valid  out  1  result available
res_ready  in  1  host accepts result
ovf  out  1  sticky: ALU result exceeded DATA_W since last start
dropped  out  1  sticky: a result was lost because res_valid was still held

Behaviour:
- Reset (async, any time, including mid-sequence): cap_x/a/b/c, rX, rS, rH, res_o = 0; res_valid, ovf, dropped = 0.
- Capture: start=1 at an edge latches x_in/a_in/b_in/c_in into cap_* and clears ovf. Inputs are not used at any other time.
- Control word is registered upstream and is sampled combinationally in the cycle it is presented. The selected load takes effect at the next rising edge, so latency is 1 cycle from control word to register update.
- ALU: full result is 2*DATA_W bits, unsigned. Add = A+B, multiply = A*B. Write-back takes the low DATA_W bits. ovf is set when any upper bit is nonzero and write-back selects the ALU result (M2 = 00/10) with LS or LH asserted.
- LS and LH asserted together: both load the same write-back value. LX is independent and may coincide with either.
- Loads read pre-edge register values, so a register used as an operand and as a destination gets the old-value result.
- Handshake:
  - completed=1 with res_valid=0: res_o <= rS (pre-edge) and res_valid <= 1 next cycle.
  - res_valid && res_ready: res_valid <= 0.
  - completed with res_valid=1 and res_ready=1 in the same cycle: the new result loads and res_valid stays 1.
  - completed with res_valid=1 and res_ready=0: the new result is discarded, res_o holds, and dropped <= 1.
  - dropped clears only on reset.
- res_o is stable while res_valid=1 and res_ready=0.
- start during an active sequence re-captures operands. Datapath registers are not cleared.

Optional Feature:
SOLVER_SAT_EN.
- Defined: when ovf would be set by an ALU write-back, the written value is all ones (2^DATA_W − 1) instead of the truncated low bits. ovf still sets.
- Undefined: truncation (wrap-around) only.

Decomposition:
- Shared package solver_pkg holds:
  - OP_ADD/OP_MUL constants.
  - M0/M1/M2 select encodings as localparam 2-bit constants.
  - Default DATA_W.
- The control block imports the same encodings.
- One sub-module, solver_alu: combinational add/multiply producing a 2*DATA_W result, with a sat option. Muxes, registers and the handshake stay in solver_datapath.

Test Plan:
1. Load: start with x=3, a=5, b=2, c=7, then LX=1 → rX=3 next cycle. Then M0=00, M1=01, OP=1, M2=00, LS=1 → rS=15, ovf=0.
2. Full sequence Horner a*x+b, then *x, then +c with x=3, a=5, b=2, c=7 → completed → res_valid=1, res_o=58 one cycle later.
3. Overflow: x=20, a=20, multiply into rS (DATA_W=8) → rS=144, ovf=1. With SOLVER_SAT_EN → rS=255, ovf=1. Next start → ovf=0.
4. Backpressure: res_ready=0 for 5 cycles after completed → res_o holds 58, res_valid=1. A second completed (rS=9) → res_o still 58, dropped=1. res_ready=1 → res_valid=0.
5. Back-to-back: completed and res_ready=1 in the same cycle while valid → res_valid stays 1, res_o takes the new rS, dropped=0.
6. Reset mid-sequence after rS=15 → all registers 0, res_valid=0, ovf=0, dropped=0 asynchronously, before the next clk edge.
